// File: rtl/mem_arb_pkg.sv
// Shared types and sizing constants for the unified-memory port arbiter.
//   state_e : sequencer state (IDLE, RD_WAIT)
//   owner_e : requester that owns the port / won the last grant (OWN_I, OWN_D)
//   MEM_LAT_MAX, CNT_W : largest supported read latency and latency counter width
package mem_arb_pkg;

  localparam int unsigned MEM_LAT_MAX = 7;
  localparam int unsigned CNT_W       = $clog2(MEM_LAT_MAX + 1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  typedef enum logic [0:0] {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the fetch and data requesters.
// Ports:
//   i_req, d_req : pending requests
//   last_win     : requester that won the most recent grant
//   any_req_c    : at least one request pending
//   win_c        : selected requester (meaningful only when any_req_c=1)
// Build option: MEM_PORT_ARB_RR_EN selects round-robin on ties; otherwise
// data always beats instruction.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_e last_win,
  output logic   any_req_c,
  output owner_e win_c
);

  assign any_req_c = i_req | d_req;

`ifdef MEM_PORT_ARB_RR_EN
  // On a tie the requester that did not win last time goes first.
  always_comb begin
    win_c = OWN_I;
    if (d_req && i_req) begin
      win_c = (last_win == OWN_D) ? OWN_I : OWN_D;
    end else if (d_req) begin
      win_c = OWN_D;
    end
  end
`else
  logic unused_last_win;
  assign unused_last_win = (last_win == OWN_D);

  assign win_c = d_req ? OWN_D : OWN_I;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported unified memory between instruction fetch and data
// load/store. Grants are combinational in IDLE; stores finish in the grant
// cycle, reads wait MEM_LAT cycles and return data with a one-cycle rvalid.
// Ports:
//   clk, reset (async, active-low)
//   i_req/i_addr -> i_gnt, i_rvalid, i_rdata        : fetch side
//   d_req/d_we/d_addr/d_wdata/d_be -> d_gnt, d_rvalid, d_rdata : data side
//   mem_en/mem_we/mem_addr/mem_wdata/mem_be -> memory, mem_rdata <- memory
// Build option: MEM_PORT_ARB_RR_EN enables round-robin tie-breaking.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);

  state_e             state_q, state_d;
  owner_e             owner_q, owner_d;
  owner_e             last_win_q, last_win_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  i_rdata_q, d_rdata_q;

  logic               any_req_c;
  owner_e             win_c;
  logic               rd_done_c;

  mem_arb_pick u_pick (
    .i_req     (i_req),
    .d_req     (d_req),
    .last_win  (last_win_q),
    .any_req_c (any_req_c),
    .win_c     (win_c)
  );

  assign rd_done_c = (state_q == RD_WAIT) && (cnt_q == CNT_W'(MEM_LAT));

  // Next state, grant/port mux and read return.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_win_d = last_win_q;
    cnt_d      = cnt_q;
    i_gnt      = 1'b0;
    d_gnt      = 1'b0;
    i_rvalid   = 1'b0;
    d_rvalid   = 1'b0;
    i_rdata    = i_rdata_q;
    d_rdata    = d_rdata_q;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_be     = '0;

    case (state_q)
      IDLE: begin
        // Reset gating keeps grants low while reset is held.
        if (reset && any_req_c) begin
          mem_en     = 1'b1;
          last_win_d = win_c;
          if (win_c == OWN_D) begin
            d_gnt     = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_be    = d_be;
          end else begin
            i_gnt    = 1'b1;
            mem_addr = i_addr;
            mem_be   = '1;
          end
          // Everything except a store waits for read data.
          if (!((win_c == OWN_D) && d_we)) begin
            state_d = RD_WAIT;
            owner_d = win_c;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      RD_WAIT: begin
        if (rd_done_c) begin
          if (owner_q == OWN_D) begin
            d_rvalid = 1'b1;
            d_rdata  = mem_rdata;
          end else begin
            i_rvalid = 1'b1;
            i_rdata  = mem_rdata;
          end
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latency counter, and rdata hold registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_I;
      last_win_q <= OWN_I;
      cnt_q      <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_win_q <= last_win_d;
      cnt_q      <= cnt_d;
      i_rdata_q  <= i_rdata;
      d_rdata_q  <= d_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: two arbiter instances (MEM_LAT=2 and MEM_LAT=7) driven
// side by side, compared every cycle against a transaction-level model that
// tracks when the port is free, when read data is due and what memory holds.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned BW = 8;
  localparam int NL = 2;

  logic clk;
  logic reset;

  logic          i_req     [NL];
  logic [AW-1:0] i_addr    [NL];
  logic          i_gnt     [NL];
  logic          i_rvalid  [NL];
  logic [DW-1:0] i_rdata   [NL];
  logic          d_req     [NL];
  logic          d_we      [NL];
  logic [AW-1:0] d_addr    [NL];
  logic [DW-1:0] d_wdata   [NL];
  logic [BW-1:0] d_be      [NL];
  logic          d_gnt     [NL];
  logic          d_rvalid  [NL];
  logic [DW-1:0] d_rdata   [NL];
  logic          mem_en    [NL];
  logic          mem_we    [NL];
  logic [AW-1:0] mem_addr  [NL];
  logic [DW-1:0] mem_wdata [NL];
  logic [BW-1:0] mem_be    [NL];
  logic [DW-1:0] mem_rdata [NL];

  for (genvar g = 0; g < NL; g++) begin : g_lane
    mem_port_arbiter #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .MEM_LAT ((g == 0) ? 2 : 7)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .i_req     (i_req[g]),
      .i_addr    (i_addr[g]),
      .i_gnt     (i_gnt[g]),
      .i_rvalid  (i_rvalid[g]),
      .i_rdata   (i_rdata[g]),
      .d_req     (d_req[g]),
      .d_we      (d_we[g]),
      .d_addr    (d_addr[g]),
      .d_wdata   (d_wdata[g]),
      .d_be      (d_be[g]),
      .d_gnt     (d_gnt[g]),
      .d_rvalid  (d_rvalid[g]),
      .d_rdata   (d_rdata[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_be    (mem_be[g]),
      .mem_rdata (mem_rdata[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench state and reference model.
  int checks;
  int errors;
  int cyc;
  int free_at  [NL];
  int due_at   [NL];
  bit due_d    [NL];
  bit last_d   [NL];
  bit i_took   [NL];
  bit d_took   [NL];
  logic [DW-1:0] due_data [NL];
  logic [DW-1:0] last_ird [NL];
  logic [DW-1:0] last_drd [NL];
  logic [DW-1:0] env_mem  [NL][128];
  logic [DW-1:0] ref_mem  [NL][128];
  logic [DW-1:0] pipe     [NL][8];

  function automatic int lat(int l);
    return (l == 0) ? 2 : 7;
  endfunction

  function automatic int idx(logic [AW-1:0] a);
    return int'(a[9:3]);
  endfunction

  function automatic bit busy();
    for (int l = 0; l < NL; l++)
      if (i_req[l] || d_req[l] || due_at[l] >= 0 || free_at[l] > cyc) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input int l, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s lane%0d cyc%0d: got %0h expected %0h", tag, l, cyc, obs, exp);
    end
  endtask

  // Evaluate one lane for the current cycle, then advance its memory.
  task automatic check_lane(input int l);
    logic          eig, edg, eiv, edv, een, ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    logic [BW-1:0] ebe;
    bit            take_d;
    int            k;
    eig = 1'b0; edg = 1'b0; eiv = 1'b0; edv = 1'b0; een = 1'b0; ewe = 1'b0;
    ea = '0; ewd = '0; ebe = '0; take_d = 1'b0;
    if (!reset) begin
      free_at[l]  = cyc;
      due_at[l]   = -1;
      last_d[l]   = 1'b0;
      last_ird[l] = '0;
      last_drd[l] = '0;
    end else begin
      if (due_at[l] == cyc) begin
        if (due_d[l]) begin edv = 1'b1; last_drd[l] = due_data[l]; end
        else begin eiv = 1'b1; last_ird[l] = due_data[l]; end
        due_at[l] = -1;
      end
      if (cyc >= free_at[l] && (i_req[l] || d_req[l])) begin
`ifdef MEM_PORT_ARB_RR_EN
        take_d = d_req[l] && (!i_req[l] || !last_d[l]);
`else
        take_d = d_req[l];
`endif
        een = 1'b1;
        last_d[l] = take_d;
        if (take_d) begin
          edg = 1'b1; ewe = d_we[l]; ea = d_addr[l]; ewd = d_wdata[l]; ebe = d_be[l];
        end else begin
          eig = 1'b1; ea = i_addr[l]; ebe = '1;
        end
        if (take_d && d_we[l]) begin
          k = idx(d_addr[l]);
          for (int b = 0; b < int'(BW); b++)
            if (d_be[l][b]) ref_mem[l][k][8*b +: 8] = d_wdata[l][8*b +: 8];
          free_at[l] = cyc + 1;
        end else begin
          due_at[l]   = cyc + lat(l);
          free_at[l]  = cyc + lat(l) + 1;
          due_d[l]    = take_d;
          due_data[l] = ref_mem[l][idx(ea)];
        end
      end
    end
    i_took[l] = eig;
    d_took[l] = edg;

    chk("i_gnt",     l, 64'(i_gnt[l]),     64'(eig));
    chk("d_gnt",     l, 64'(d_gnt[l]),     64'(edg));
    chk("i_rvalid",  l, 64'(i_rvalid[l]),  64'(eiv));
    chk("d_rvalid",  l, 64'(d_rvalid[l]),  64'(edv));
    chk("i_rdata",   l, i_rdata[l],        last_ird[l]);
    chk("d_rdata",   l, d_rdata[l],        last_drd[l]);
    chk("mem_en",    l, 64'(mem_en[l]),    64'(een));
    chk("mem_we",    l, 64'(mem_we[l]),    64'(ewe));
    chk("mem_addr",  l, 64'(mem_addr[l]),  64'(ea));
    chk("mem_wdata", l, mem_wdata[l],      ewd);
    chk("mem_be",    l, 64'(mem_be[l]),    64'(ebe));

    // Memory macro: unreset storage plus a read pipeline of depth lat(l).
    for (int s = lat(l) - 1; s > 0; s--) pipe[l][s] = pipe[l][s-1];
    if (mem_en[l] && !mem_we[l]) pipe[l][0] = env_mem[l][idx(mem_addr[l])];
    else pipe[l][0] = {$urandom, $urandom};
    if (mem_en[l] && mem_we[l]) begin
      k = idx(mem_addr[l]);
      for (int b = 0; b < int'(BW); b++)
        if (mem_be[l][b]) env_mem[l][k][8*b +: 8] = mem_wdata[l][8*b +: 8];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int l = 0; l < NL; l++) check_lane(l);
    @(posedge clk);
    #1;
    cyc++;
    for (int l = 0; l < NL; l++) begin
      mem_rdata[l] = pipe[l][lat(l) - 1];
      if (i_took[l]) i_req[l] = 1'b0;
      if (d_took[l]) d_req[l] = 1'b0;
    end
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while (busy() && n < max) begin
      tick();
      n++;
    end
    checks++;
    assert (!busy()) else begin
      errors++;
      $error("FAIL drain_timeout cyc%0d: still busy after %0d cycles, expected idle", cyc, n);
    end
  endtask

  task automatic req_i(input logic [AW-1:0] a);
    for (int l = 0; l < NL; l++) begin
      i_req[l]  = 1'b1;
      i_addr[l] = a;
    end
  endtask

  task automatic req_d(input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [BW-1:0] be);
    for (int l = 0; l < NL; l++) begin
      d_req[l]   = 1'b1;
      d_we[l]    = we;
      d_addr[l]  = a;
      d_wdata[l] = wd;
      d_be[l]    = be;
    end
  endtask

  task automatic rand_req(input int pi, input int pd);
    for (int l = 0; l < NL; l++) begin
      if (!i_req[l] && int'($urandom_range(99)) < pi) begin
        i_req[l]  = 1'b1;
        i_addr[l] = $urandom;
      end
      if (!d_req[l] && int'($urandom_range(99)) < pd) begin
        d_req[l]   = 1'b1;
        d_we[l]    = 1'($urandom_range(1));
        d_addr[l]  = $urandom;
        d_wdata[l] = {$urandom, $urandom};
        d_be[l]    = 8'($urandom);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    reset  = 1'b0;
    for (int l = 0; l < NL; l++) begin
      i_req[l] = 1'b0; i_addr[l] = '0;
      d_req[l] = 1'b0; d_we[l] = 1'b0; d_addr[l] = '0; d_wdata[l] = '0; d_be[l] = '0;
      mem_rdata[l] = '0;
      free_at[l] = 0; due_at[l] = -1; due_d[l] = 1'b0; last_d[l] = 1'b0;
      i_took[l] = 1'b0; d_took[l] = 1'b0;
      due_data[l] = '0; last_ird[l] = '0; last_drd[l] = '0;
      for (int s = 0; s < 8; s++) pipe[l][s] = '0;
      for (int k = 0; k < 128; k++) begin
        env_mem[l][k] = {$urandom, $urandom};
        ref_mem[l][k] = env_mem[l][k];
      end
      env_mem[l][32] = 64'hDEAD_BEEF;
      ref_mem[l][32] = 64'hDEAD_BEEF;
    end

    // Reset state, with a request held to confirm grants stay low.
    req_i(32'h40);
    tick();
    tick();
    reset = 1'b1;
    drain(30);

    // Fetch 0x100 followed by a second fetch held behind it.
    req_i(32'h100);
    tick();
    req_i(32'h108);
    drain(30);

    // Contended fetch vs load from 0x200.
    req_i(32'h0);
    req_d(1'b0, 32'h200, 64'h0, 8'h00);
    drain(40);

    // Three back-to-back partial stores, then read one back.
    req_d(1'b1, 32'h10, 64'h1111_2222_3333_4444, 8'h0F);
    tick();
    req_d(1'b1, 32'h18, 64'h5555_6666_7777_8888, 8'h0F);
    tick();
    req_d(1'b1, 32'h20, 64'h9999_AAAA_BBBB_CCCC, 8'h0F);
    tick();
    drain(10);
    req_i(32'h18);
    drain(30);

    // Store followed immediately by a fetch.
    req_d(1'b1, 32'h30, 64'h0123_4567_89AB_CDEF, 8'hFF);
    tick();
    req_i(32'h30);
    drain(30);

    // Load with a fetch held for its whole duration.
    req_d(1'b0, 32'h208, 64'h0, 8'h00);
    tick();
    req_i(32'h100);
    drain(40);

    // Sustained contention: both sides always requesting.
    for (int n = 0; n < 40; n++) begin
      rand_req(100, 100);
      tick();
    end
    drain(40);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      rand_req(40, 40);
      tick();
    end
    drain(40);

    // Reset one cycle into RD_WAIT; the dropped read must never return.
    req_i(32'h100);
    tick();
    reset = 1'b0;
    req_i(32'h108);
    tick();
    tick();
    tick();
    reset = 1'b1;
    drain(40);

    for (int n = 0; n < 200; n++) begin
      rand_req(50, 50);
      tick();
    end
    drain(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
